// File: rtl/rvfi_trace_gen.sv
// rvfi_trace_gen: retirement-side RVFI packet producer (holds one record, waits for mem response, emits one-cycle packet)
// Ports: g_clk/g_reset (sync, active-high); rt_* retirement record in with rt_valid/rt_ready handshake;
// mem_rsp_* load/store response; rvfi_* one-cycle trace packet qualified by rvfi_valid.
module rvfi_trace_gen #(
  parameter int XLEN    = 32,
  parameter int ORDER_W = 64
) (
  input  logic               g_clk,
  input  logic               g_reset,
  input  logic               rt_valid,
  output logic               rt_ready,
  input  logic [31:0]        rt_insn,
  input  logic [31:0]        rt_pc,
  input  logic [31:0]        rt_npc,
  input  logic               rt_trap,
  input  logic [4:0]         rt_rs1_addr,
  input  logic [4:0]         rt_rs2_addr,
  input  logic [4:0]         rt_rs3_addr,
  input  logic [XLEN-1:0]    rt_rs1_rdata,
  input  logic [XLEN-1:0]    rt_rs2_rdata,
  input  logic [XLEN-1:0]    rt_rs3_rdata,
  input  logic [4:0]         rt_rd_addr,
  input  logic [XLEN-1:0]    rt_rd_wdata,
  input  logic               rt_rd_wide,
  input  logic [XLEN-1:0]    rt_rd_wdatahi,
  input  logic               rt_mem_pend,
  input  logic [XLEN-1:0]    rt_mem_addr,
  input  logic [3:0]         rt_mem_rmask,
  input  logic [3:0]         rt_mem_wmask,
  input  logic [XLEN-1:0]    rt_mem_wdata,
  input  logic               mem_rsp_valid,
  input  logic [XLEN-1:0]    mem_rsp_rdata,
  input  logic               mem_rsp_error,
  output logic               rvfi_valid,
  output logic [ORDER_W-1:0] rvfi_order,
  output logic [31:0]        rvfi_insn,
  output logic [31:0]        rvfi_pc_rdata,
  output logic [31:0]        rvfi_pc_wdata,
  output logic               rvfi_trap,
  output logic               rvfi_intr,
  output logic               rvfi_halt,
  output logic [4:0]         rvfi_rs1_addr,
  output logic [4:0]         rvfi_rs2_addr,
  output logic [4:0]         rvfi_rs3_addr,
  output logic [XLEN-1:0]    rvfi_rs1_rdata,
  output logic [XLEN-1:0]    rvfi_rs2_rdata,
  output logic [XLEN-1:0]    rvfi_rs3_rdata,
  output logic [4:0]         rvfi_rd_addr,
  output logic [XLEN-1:0]    rvfi_rd_wdata,
  output logic [XLEN-1:0]    rvfi_rd_wdatahi,
  output logic               rvfi_rd_wide,
  output logic [XLEN-1:0]    rvfi_mem_addr,
  output logic [3:0]         rvfi_mem_rmask,
  output logic [3:0]         rvfi_mem_wmask,
  output logic [XLEN-1:0]    rvfi_mem_rdata,
  output logic [XLEN-1:0]    rvfi_mem_wdata
);
  typedef enum logic [1:0] {IDLE, WAIT_MEM, EMIT} state_t;
  typedef struct packed {
    logic [31:0]     insn;
    logic [31:0]     pc;
    logic [31:0]     npc;
    logic            trap;
    logic [4:0]      rs1_addr;
    logic [4:0]      rs2_addr;
    logic [4:0]      rs3_addr;
    logic [XLEN-1:0] rs1_rdata;
    logic [XLEN-1:0] rs2_rdata;
    logic [XLEN-1:0] rs3_rdata;
    logic [4:0]      rd_addr;
    logic [XLEN-1:0] rd_wdata;
    logic            rd_wide;
    logic [XLEN-1:0] rd_wdatahi;
    logic [XLEN-1:0] mem_addr;
    logic [3:0]      rmask;
    logic [3:0]      wmask;
    logic [XLEN-1:0] mem_rdata;
    logic [XLEN-1:0] mem_wdata;
  } rec_t;
  state_t             state, state_n;
  rec_t               h;
  logic [ORDER_W-1:0] order;
  logic               intr;
  logic               accept;
  always_comb begin
    rt_ready = !g_reset && state != WAIT_MEM;
    accept   = rt_valid && rt_ready;
    state_n  = state == WAIT_MEM ? (mem_rsp_valid ? EMIT : WAIT_MEM)
             : accept            ? (rt_mem_pend ? WAIT_MEM : EMIT)
             :                     IDLE;
  end
  always_ff @(posedge g_clk) begin
    if (g_reset) begin
      state <= IDLE;
      h     <= '0;
      order <= '0;
      intr  <= 1'b0;
    end else begin
      state <= state_n;
      if (accept) begin
        h.insn       <= rt_insn;
        h.pc         <= rt_pc;
        h.npc        <= rt_npc;
        h.trap       <= rt_trap;
        h.rs1_addr   <= rt_rs1_addr;
        h.rs2_addr   <= rt_rs2_addr;
        h.rs3_addr   <= rt_rs3_addr;
        h.rs1_rdata  <= rt_rs1_rdata;
        h.rs2_rdata  <= rt_rs2_rdata;
        h.rs3_rdata  <= rt_rs3_rdata;
        h.rd_addr    <= rt_rd_addr;
        h.rd_wdata   <= rt_rd_wdata;
        h.rd_wide    <= rt_rd_wide;
        h.rd_wdatahi <= rt_rd_wdatahi;
        h.mem_addr   <= rt_mem_addr;
        h.rmask      <= rt_mem_rmask;
        h.wmask      <= rt_mem_wmask;
        h.mem_rdata  <= '0;
        h.mem_wdata  <= rt_mem_wdata;
      end else if (state == WAIT_MEM && mem_rsp_valid) begin
        h.mem_rdata <= mem_rsp_rdata;
        // A faulting access retires as a trap with no architectural effects
        if (mem_rsp_error) begin
          h.trap    <= 1'b1;
          h.rd_addr <= '0;
          h.rd_wide <= 1'b0;
          h.rmask   <= '0;
          h.wmask   <= '0;
        end
      end
      // Trap in this packet flags the following packet; otherwise the flag is consumed
      if (state == EMIT) begin
        order <= order + ORDER_W'(1);
        intr  <= h.trap;
      end
    end
  end
  assign rvfi_valid      = state == EMIT && !g_reset;
  assign rvfi_order      = order;
  assign rvfi_insn       = h.insn;
  assign rvfi_pc_rdata   = h.pc;
  assign rvfi_pc_wdata   = h.npc;
  assign rvfi_trap       = h.trap;
  assign rvfi_intr       = intr;
  assign rvfi_halt       = 1'b0;
  assign rvfi_rs1_addr   = h.rs1_addr;
  assign rvfi_rs2_addr   = h.rs2_addr;
  assign rvfi_rs3_addr   = h.rs3_addr;
  assign rvfi_rs1_rdata  = h.rs1_rdata;
  assign rvfi_rs2_rdata  = h.rs2_rdata;
  assign rvfi_rs3_rdata  = h.rs3_rdata;
  assign rvfi_rd_addr    = h.rd_addr;
  assign rvfi_rd_wdata   = h.rd_addr == '0 ? '0 : h.rd_wdata;
  assign rvfi_rd_wide    = h.rd_wide;
  assign rvfi_rd_wdatahi = h.rd_wide ? h.rd_wdatahi : '0;
  assign rvfi_mem_addr   = h.mem_addr;
  assign rvfi_mem_rmask  = h.rmask;
  assign rvfi_mem_wmask  = h.wmask;
  assign rvfi_mem_rdata  = h.rmask == '0 ? '0 : h.mem_rdata;
  assign rvfi_mem_wdata  = h.wmask == '0 ? '0 : h.mem_wdata;
endmodule

// File: tb/tb_rvfi_trace_gen.sv
// tb_rvfi_trace_gen: scoreboard bench for rvfi_trace_gen
module tb_rvfi_trace_gen;
  logic        clk = 1'b0;
  logic        rst;
  logic        rt_valid, rt_ready, rt_trap, rt_rd_wide, rt_mem_pend;
  logic [31:0] rt_insn, rt_pc, rt_npc;
  logic [4:0]  rt_rs1_addr, rt_rs2_addr, rt_rs3_addr, rt_rd_addr;
  logic [31:0] rt_rs1_rdata, rt_rs2_rdata, rt_rs3_rdata, rt_rd_wdata, rt_rd_wdatahi;
  logic [31:0] rt_mem_addr, rt_mem_wdata;
  logic [3:0]  rt_mem_rmask, rt_mem_wmask;
  logic        mem_rsp_valid, mem_rsp_error;
  logic [31:0] mem_rsp_rdata;
  logic        rvfi_valid, rvfi_trap, rvfi_intr, rvfi_halt, rvfi_rd_wide;
  logic [63:0] rvfi_order;
  logic [31:0] rvfi_insn, rvfi_pc_rdata, rvfi_pc_wdata;
  logic [4:0]  rvfi_rs1_addr, rvfi_rs2_addr, rvfi_rs3_addr, rvfi_rd_addr;
  logic [31:0] rvfi_rs1_rdata, rvfi_rs2_rdata, rvfi_rs3_rdata, rvfi_rd_wdata, rvfi_rd_wdatahi;
  logic [31:0] rvfi_mem_addr, rvfi_mem_rdata, rvfi_mem_wdata;
  logic [3:0]  rvfi_mem_rmask, rvfi_mem_wmask;
  always #5 clk = ~clk;
  rvfi_trace_gen #(.XLEN(32), .ORDER_W(64)) dut (
    .g_clk(clk), .g_reset(rst), .rt_valid(rt_valid), .rt_ready(rt_ready),
    .rt_insn(rt_insn), .rt_pc(rt_pc), .rt_npc(rt_npc), .rt_trap(rt_trap),
    .rt_rs1_addr(rt_rs1_addr), .rt_rs2_addr(rt_rs2_addr), .rt_rs3_addr(rt_rs3_addr),
    .rt_rs1_rdata(rt_rs1_rdata), .rt_rs2_rdata(rt_rs2_rdata), .rt_rs3_rdata(rt_rs3_rdata),
    .rt_rd_addr(rt_rd_addr), .rt_rd_wdata(rt_rd_wdata), .rt_rd_wide(rt_rd_wide),
    .rt_rd_wdatahi(rt_rd_wdatahi), .rt_mem_pend(rt_mem_pend), .rt_mem_addr(rt_mem_addr),
    .rt_mem_rmask(rt_mem_rmask), .rt_mem_wmask(rt_mem_wmask), .rt_mem_wdata(rt_mem_wdata),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_rdata(mem_rsp_rdata), .mem_rsp_error(mem_rsp_error),
    .rvfi_valid(rvfi_valid), .rvfi_order(rvfi_order), .rvfi_insn(rvfi_insn),
    .rvfi_pc_rdata(rvfi_pc_rdata), .rvfi_pc_wdata(rvfi_pc_wdata), .rvfi_trap(rvfi_trap),
    .rvfi_intr(rvfi_intr), .rvfi_halt(rvfi_halt),
    .rvfi_rs1_addr(rvfi_rs1_addr), .rvfi_rs2_addr(rvfi_rs2_addr), .rvfi_rs3_addr(rvfi_rs3_addr),
    .rvfi_rs1_rdata(rvfi_rs1_rdata), .rvfi_rs2_rdata(rvfi_rs2_rdata), .rvfi_rs3_rdata(rvfi_rs3_rdata),
    .rvfi_rd_addr(rvfi_rd_addr), .rvfi_rd_wdata(rvfi_rd_wdata), .rvfi_rd_wdatahi(rvfi_rd_wdatahi),
    .rvfi_rd_wide(rvfi_rd_wide), .rvfi_mem_addr(rvfi_mem_addr), .rvfi_mem_rmask(rvfi_mem_rmask),
    .rvfi_mem_wmask(rvfi_mem_wmask), .rvfi_mem_rdata(rvfi_mem_rdata), .rvfi_mem_wdata(rvfi_mem_wdata)
  );
  typedef struct {
    logic [31:0] pc, npc, insn;
    logic        trap;
    logic [4:0]  rd;
    logic [31:0] wd;
    logic        wide;
    logic [31:0] hi;
    logic        pend;
    logic [3:0]  rm, wm;
    logic [31:0] addr, mwd, mrd, rs1;
    logic [63:0] order;
    logic        intr;
  } rec_t;
  rec_t        q[$];
  int          n_vec = 0;
  int          n_err = 0;
  int          cyc = 0;
  logic [63:0] m_order = '0;
  logic        m_trap_prev = 1'b0;
  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, act, exp);
    end
  endtask
  task automatic tick;
    rec_t e;
    @(posedge clk);
    #1;
    cyc++;
    if (rvfi_valid === 1'b1) begin
      if (q.size() == 0) chk("spurious_valid", {63'd0, rvfi_valid}, 64'd0);
      else begin
        e = q.pop_front();
        chk("order", rvfi_order, e.order);
        chk("intr", {63'd0, rvfi_intr}, {63'd0, e.intr});
        chk("trap", {63'd0, rvfi_trap}, {63'd0, e.trap});
        chk("halt", {63'd0, rvfi_halt}, 64'd0);
        chk("insn", {32'd0, rvfi_insn}, {32'd0, e.insn});
        chk("pc_rdata", {32'd0, rvfi_pc_rdata}, {32'd0, e.pc});
        chk("pc_wdata", {32'd0, rvfi_pc_wdata}, {32'd0, e.npc});
        chk("rs1_rdata", {32'd0, rvfi_rs1_rdata}, {32'd0, e.rs1});
        chk("rs3_rdata", {32'd0, rvfi_rs3_rdata}, {32'd0, e.rs1 + 32'd2});
        chk("rd_addr", {59'd0, rvfi_rd_addr}, {59'd0, e.rd});
        chk("rd_wdata", {32'd0, rvfi_rd_wdata}, {32'd0, e.wd});
        chk("rd_wide", {63'd0, rvfi_rd_wide}, {63'd0, e.wide});
        chk("rd_wdatahi", {32'd0, rvfi_rd_wdatahi}, {32'd0, e.hi});
        chk("mem_addr", {32'd0, rvfi_mem_addr}, {32'd0, e.addr});
        chk("mem_rmask", {60'd0, rvfi_mem_rmask}, {60'd0, e.rm});
        chk("mem_wmask", {60'd0, rvfi_mem_wmask}, {60'd0, e.wm});
        chk("mem_rdata", {32'd0, rvfi_mem_rdata}, {32'd0, e.mrd});
        chk("mem_wdata", {32'd0, rvfi_mem_wdata}, {32'd0, e.mwd});
      end
    end
    if (cyc > 5000) begin
      $display("FAIL timeout: cycle budget exceeded");
      $fatal(1);
    end
  endtask
  task automatic idle(input int n);
    rt_valid = 1'b0;
    repeat (n) tick;
  endtask
  function automatic rec_t mk(input logic [31:0] pc);
    rec_t r;
    r = '{pc: pc, npc: pc + 32'd4, insn: pc ^ 32'h0000_0013, trap: 1'b0, rd: 5'd1, wd: pc + 32'h1000,
          wide: 1'b0, hi: 32'h0, pend: 1'b0, rm: 4'h0, wm: 4'h0, addr: 32'h0, mwd: 32'h0, mrd: 32'h0,
          rs1: pc ^ 32'hCAFE_0000, order: 64'd0, intr: 1'b0};
    return r;
  endfunction
  task automatic send(input rec_t r, input int dly, input logic [31:0] rdata, input logic err, input logic early);
    rec_t e;
    chk("ready_before_accept", {63'd0, rt_ready}, 64'd1);
    rt_insn = r.insn; rt_pc = r.pc; rt_npc = r.npc; rt_trap = r.trap;
    rt_rs1_addr = 5'd1; rt_rs2_addr = 5'd2; rt_rs3_addr = 5'd3;
    rt_rs1_rdata = r.rs1; rt_rs2_rdata = r.rs1 + 32'd1; rt_rs3_rdata = r.rs1 + 32'd2;
    rt_rd_addr = r.rd; rt_rd_wdata = r.wd; rt_rd_wide = r.wide; rt_rd_wdatahi = r.hi;
    rt_mem_pend = r.pend; rt_mem_addr = r.addr; rt_mem_rmask = r.rm; rt_mem_wmask = r.wm;
    rt_mem_wdata = r.mwd;
    rt_valid = 1'b1;
    if (early) begin
      mem_rsp_valid = 1'b1; mem_rsp_rdata = 32'hBADB_AD00; mem_rsp_error = 1'b1;
    end
    e = r;
    e.order = m_order;
    e.intr = m_trap_prev;
    e.mrd = r.pend ? rdata : 32'h0;
    if (r.pend && err) begin
      e.trap = 1'b1; e.rd = 5'd0; e.wide = 1'b0; e.rm = 4'h0; e.wm = 4'h0;
    end
    if (e.rd == 5'd0) e.wd = 32'h0;
    if (!e.wide) e.hi = 32'h0;
    if (e.rm == 4'h0) e.mrd = 32'h0;
    if (e.wm == 4'h0) e.mwd = 32'h0;
    m_order = m_order + 64'd1;
    m_trap_prev = e.trap;
    q.push_back(e);
    tick;
    mem_rsp_valid = 1'b0; mem_rsp_error = 1'b0;
    if (!r.pend) chk("latency_nomem", {63'd0, rvfi_valid}, 64'd1);
    else begin
      rt_valid = 1'b0;
      chk("no_valid_while_wait", {63'd0, rvfi_valid}, 64'd0);
      for (int i = 0; i < dly; i++) begin
        chk("ready_low_wait", {63'd0, rt_ready}, 64'd0);
        if (i == dly - 1) begin
          mem_rsp_valid = 1'b1; mem_rsp_rdata = rdata; mem_rsp_error = err;
        end
        tick;
      end
      mem_rsp_valid = 1'b0; mem_rsp_error = 1'b0;
      chk("latency_mem", {63'd0, rvfi_valid}, 64'd1);
    end
  endtask
  task automatic do_reset;
    rst = 1'b1;
    q.delete();
    m_order = '0;
    m_trap_prev = 1'b0;
    tick;
    chk("rst_ready_low", {63'd0, rt_ready}, 64'd0);
    chk("rst_valid", {63'd0, rvfi_valid}, 64'd0);
    chk("rst_order", rvfi_order, 64'd0);
    rst = 1'b0;
    #1;
    chk("ready_after_rst", {63'd0, rt_ready}, 64'd1);
  endtask
  initial begin
    rec_t r;
    rst = 1'b1; rt_valid = 1'b0; rt_trap = 1'b0; rt_rd_wide = 1'b0; rt_mem_pend = 1'b0;
    rt_insn = '0; rt_pc = '0; rt_npc = '0;
    rt_rs1_addr = '0; rt_rs2_addr = '0; rt_rs3_addr = '0;
    rt_rs1_rdata = '0; rt_rs2_rdata = '0; rt_rs3_rdata = '0;
    rt_rd_addr = '0; rt_rd_wdata = '0; rt_rd_wdatahi = '0;
    rt_mem_addr = '0; rt_mem_rmask = '0; rt_mem_wmask = '0; rt_mem_wdata = '0;
    mem_rsp_valid = 1'b0; mem_rsp_rdata = '0; mem_rsp_error = 1'b0;
    tick;
    chk("rst_pc_rdata", {32'd0, rvfi_pc_rdata}, 64'd0);
    chk("rst_rd_wdata", {32'd0, rvfi_rd_wdata}, 64'd0);
    chk("rst_intr", {63'd0, rvfi_intr}, 64'd0);
    do_reset;
    r = mk(32'h100); r.rd = 5'd5; r.wd = 32'hDEAD_BEEF;
    send(r, 0, 32'h0, 1'b0, 1'b0);
    idle(1);
    chk("single_pulse", {63'd0, rvfi_valid}, 64'd0);
    r = mk(32'h104); r.rd = 5'd0; r.wd = 32'h1234; r.wide = 1'b0; r.hi = 32'h55;
    send(r, 0, 32'h0, 1'b0, 1'b0);
    idle(1);
    r = mk(32'h108); r.rd = 5'd7; r.wide = 1'b1; r.hi = 32'h55;
    send(r, 0, 32'h0, 1'b0, 1'b0);
    idle(2);
    r = mk(32'h10C); r.pend = 1'b1; r.rm = 4'hF; r.addr = 32'h2000; r.rd = 5'd9;
    send(r, 3, 32'hA5A5_A5A5, 1'b0, 1'b1);
    idle(1);
    r = mk(32'h110); r.pend = 1'b1; r.rm = 4'hF; r.addr = 32'h2000; r.rd = 5'd9;
    send(r, 3, 32'hA5A5_A5A5, 1'b1, 1'b0);
    idle(1);
    send(mk(32'h114), 0, 32'h0, 1'b0, 1'b0);
    send(mk(32'h118), 0, 32'h0, 1'b0, 1'b0);
    idle(1);
    r = mk(32'h11C); r.pend = 1'b1; r.wm = 4'h3; r.mwd = 32'h0000_BEEF; r.addr = 32'h3000; r.rd = 5'd0;
    send(r, 1, 32'h1111_2222, 1'b0, 1'b0);
    r = mk(32'h120); r.trap = 1'b1; r.wm = 4'h0; r.mwd = 32'h7777_7777;
    send(r, 0, 32'h0, 1'b0, 1'b0);
    send(mk(32'h124), 0, 32'h0, 1'b0, 1'b0);
    idle(2);
    r = mk(32'h200); r.pend = 1'b1; r.rm = 4'hF; r.addr = 32'h4000;
    rt_pc = r.pc; rt_npc = r.npc; rt_insn = r.insn; rt_mem_pend = 1'b1; rt_mem_rmask = 4'hF;
    rt_valid = 1'b1;
    tick;
    rt_valid = 1'b0;
    tick;
    chk("wait_ready_low", {63'd0, rt_ready}, 64'd0);
    do_reset;
    idle(3);
    for (int i = 0; i < 8; i++) send(mk(32'h400 + 32'(i) * 32'd4), 0, 32'h0, 1'b0, 1'b0);
    idle(2);
    chk("burst_end_idle", {63'd0, rvfi_valid}, 64'd0);
    chk("queue_drained", 64'(q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
